// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART responder: register map,
// STATUS bit positions, CPU access widths and serial FSM states.
package uart_pkg;
  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_RXDATA  = 2'd1;
  localparam logic [1:0] REG_STATUS  = 2'd2;
  localparam logic [1:0] REG_DIVISOR = 2'd3;

  localparam int ST_TX_FULL      = 0;
  localparam int ST_TX_EMPTY     = 1;
  localparam int ST_RX_VALID     = 2;
  localparam int ST_RX_OVERRUN   = 3;
  localparam int ST_TX_OVERFLOW  = 4;
  localparam int ST_RX_FRAME_ERR = 5;
  localparam int ST_TX_BUSY      = 6;

  typedef enum logic [1:0] {
    WIDTH_NONE = 2'd0,
    WIDTH_BYTE = 2'd1,
    WIDTH_HALF = 2'd2,
    WIDTH_WORD = 2'd3
  } width_e;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_e;

  localparam logic [15:0] MIN_DIV = 16'd4;

  function automatic logic [15:0] eff_div(input logic [15:0] div);
    return (div < MIN_DIV) ? MIN_DIV : div;
  endfunction

  // Lane-shift a register value, then truncate to the access width and extend.
  function automatic logic [31:0] format_load(input logic [31:0] value, input logic [1:0] lane,
                                              input width_e width, input logic zext);
    logic [31:0] shifted;
    shifted = value >> {lane, 3'b000};
    case (width)
      WIDTH_BYTE: return zext ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      WIDTH_HALF: return zext ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default:    return shifted;
    endcase
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head read; push when full and pop when
// empty are ignored. DEPTH must be a power of two.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign full    = count[AW];
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // NOTE: storage has no reset; the count alone defines which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + {{(AW-1){1'b0}}, 1'b1};
      if (do_pop)  rd_ptr <= rd_ptr + {{(AW-1){1'b0}}, 1'b1};
      case ({do_push, do_pop})
        2'b10:   count <= count + {{AW{1'b0}}, 1'b1};
        2'b01:   count <= count - {{AW{1'b0}}, 1'b1};
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/uart_mmio_responder.sv
// UART peripheral on the CPU data port: TX FIFO + serializer, RX deserializer
// with a one-byte holding register, sticky error flags, registered load data.
module uart_mmio_responder
  import uart_pkg::*;
#(
  parameter int          TX_DEPTH  = 8,
  parameter logic [15:0] DIV_RESET = 16'd868
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_sel,
  input  logic [31:0] i_data_addr,
  input  logic [31:0] i_data_data,
  input  logic [1:0]  i_data_width,
  input  logic        i_data_we,
  input  logic        i_data_zeroextend,
  output logic [31:0] o_data_data,
  input  logic        i_uart_rx,
  output logic        o_uart_tx
);
  width_e      width;
  logic [1:0]  lane, regsel;
  logic        access, wr, wr_tx, wr_rx, wr_status, wr_div;
  logic        unused_bits;

  assign width       = width_e'(i_data_width);
  assign lane        = i_data_addr[1:0];
  assign regsel      = i_data_addr[3:2];
  assign access      = i_sel && (width != WIDTH_NONE);
  assign wr          = access && i_data_we && (lane == 2'd0);
  assign wr_tx       = wr && (regsel == REG_TXDATA);
  assign wr_rx       = wr && (regsel == REG_RXDATA);
  assign wr_status   = wr && (regsel == REG_STATUS);
  assign wr_div      = wr && (regsel == REG_DIVISOR);
  assign unused_bits = ^{i_data_addr[31:4], i_data_data[31:16]};

  logic [15:0] divisor;
  logic        tx_full, tx_empty, tx_pop;
  logic [7:0]  tx_head;
  logic        rx_valid, rx_overrun, tx_overflow, rx_frame_err;
  logic [7:0]  rx_byte;
  logic [6:0]  status;
  logic [31:0] reg_val;

  uart_state_e tx_state, tx_state_n;
  logic [15:0] tx_cnt, tx_cnt_n, tx_div, tx_div_n;
  logic [2:0]  tx_bit, tx_bit_n;
  logic [7:0]  tx_shift, tx_shift_n;
  logic        tx_line, tx_line_n, tx_start;

  uart_state_e rx_state, rx_state_n;
  logic [15:0] rx_cnt, rx_cnt_n, rx_div, rx_div_n;
  logic [2:0]  rx_bit, rx_bit_n;
  logic [7:0]  rx_shift, rx_shift_n;
  logic        rx_s1, rx_s2, rx_s3, rx_deliver, rx_bad_stop;

  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(i_clk), .rst_n(i_rst_n), .push(wr_tx), .pop(tx_pop), .wdata(i_data_data[7:0]),
    .rdata(tx_head), .full(tx_full), .empty(tx_empty)
  );

  always_comb begin
    status                  = '0;
    status[ST_TX_FULL]      = tx_full;
    status[ST_TX_EMPTY]     = tx_empty;
    status[ST_RX_VALID]     = rx_valid;
    status[ST_RX_OVERRUN]   = rx_overrun;
    status[ST_TX_OVERFLOW]  = tx_overflow;
    status[ST_RX_FRAME_ERR] = rx_frame_err;
    status[ST_TX_BUSY]      = !tx_empty || (tx_state != S_IDLE);
    case (regsel)
      REG_RXDATA:  reg_val = {23'h0, rx_valid, rx_byte};
      REG_STATUS:  reg_val = {25'h0, status};
      REG_DIVISOR: reg_val = {16'h0, divisor};
      default:     reg_val = '0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_data_data  <= '0;
      divisor      <= DIV_RESET;
      tx_overflow  <= 1'b0;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_valid     <= 1'b0;
      rx_byte      <= '0;
    end else begin
      if (access) o_data_data <= format_load(reg_val, lane, width, i_data_zeroextend);
      if (wr_div) begin
        if (width == WIDTH_BYTE) divisor[7:0] <= i_data_data[7:0];
        else                     divisor      <= i_data_data[15:0];
      end
      // A flag being set on the same edge as its write-1-clear stays set.
      tx_overflow  <= (wr_tx && tx_full) ||
                      (tx_overflow && !(wr_status && i_data_data[ST_TX_OVERFLOW]));
      rx_overrun   <= (rx_deliver && rx_valid && !wr_rx) ||
                      (rx_overrun && !(wr_status && i_data_data[ST_RX_OVERRUN]));
      rx_frame_err <= (rx_deliver && rx_bad_stop) ||
                      (rx_frame_err && !(wr_status && i_data_data[ST_RX_FRAME_ERR]));
      if (rx_deliver && (!rx_valid || wr_rx)) begin
        rx_byte  <= rx_shift;
        rx_valid <= 1'b1;
      end else if (wr_rx) begin
        rx_valid <= 1'b0;
      end
    end
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt + 16'd1;
    tx_div_n   = tx_div;
    tx_bit_n   = tx_bit;
    tx_shift_n = tx_shift;
    tx_start   = 1'b0;
    tx_pop     = 1'b0;
    case (tx_state)
      S_IDLE: begin
        tx_cnt_n = '0;
        tx_start = !tx_empty;
      end
      S_START: if (tx_cnt == tx_div - 16'd1) begin
        tx_state_n = S_DATA;
        tx_cnt_n   = '0;
        tx_bit_n   = '0;
      end
      S_DATA: if (tx_cnt == tx_div - 16'd1) begin
        tx_cnt_n   = '0;
        tx_shift_n = tx_shift >> 1;
        tx_bit_n   = tx_bit + 3'd1;
        if (tx_bit == 3'd7) tx_state_n = S_STOP;
      end
      default: if (tx_cnt == tx_div - 16'd1) begin
        tx_cnt_n   = '0;
        tx_state_n = S_IDLE;
        tx_start   = !tx_empty;
      end
    endcase
    // Divisor is latched per frame so a mid-frame DIVISOR write cannot distort it.
    if (tx_start) begin
      tx_state_n = S_START;
      tx_cnt_n   = '0;
      tx_pop     = 1'b1;
      tx_shift_n = tx_head;
      tx_div_n   = eff_div(divisor);
    end
    case (tx_state_n)
      S_START: tx_line_n = 1'b0;
      S_DATA:  tx_line_n = tx_shift_n[0];
      default: tx_line_n = 1'b1;
    endcase
  end

  always_comb begin
    rx_state_n  = rx_state;
    rx_cnt_n    = rx_cnt + 16'd1;
    rx_div_n    = rx_div;
    rx_bit_n    = rx_bit;
    rx_shift_n  = rx_shift;
    rx_deliver  = 1'b0;
    rx_bad_stop = 1'b0;
    case (rx_state)
      S_IDLE: begin
        rx_cnt_n = '0;
        if (rx_s3 && !rx_s2) begin
          rx_state_n = S_START;
          rx_div_n   = eff_div(divisor);
        end
      end
      S_START: if (rx_cnt == (rx_div >> 1) - 16'd1) begin
        rx_cnt_n   = '0;
        rx_bit_n   = '0;
        rx_state_n = rx_s2 ? S_IDLE : S_DATA;
      end
      S_DATA: if (rx_cnt == rx_div - 16'd1) begin
        rx_cnt_n   = '0;
        rx_shift_n = {rx_s2, rx_shift[7:1]};
        rx_bit_n   = rx_bit + 3'd1;
        if (rx_bit == 3'd7) rx_state_n = S_STOP;
      end
      default: if (rx_cnt == rx_div - 16'd1) begin
        rx_cnt_n    = '0;
        rx_state_n  = S_IDLE;
        rx_deliver  = 1'b1;
        rx_bad_stop = !rx_s2;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_div   <= MIN_DIV;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_line  <= 1'b1;
      rx_state <= S_IDLE;
      rx_cnt   <= '0;
      rx_div   <= MIN_DIV;
      rx_bit   <= '0;
      rx_shift <= '0;
      {rx_s1, rx_s2, rx_s3} <= 3'b111;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_div   <= tx_div_n;
      tx_bit   <= tx_bit_n;
      tx_shift <= tx_shift_n;
      tx_line  <= tx_line_n;
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_div   <= rx_div_n;
      rx_bit   <= rx_bit_n;
      rx_shift <= rx_shift_n;
      {rx_s1, rx_s2, rx_s3} <= {i_uart_rx, rx_s1, rx_s2};
    end
  end

  assign o_uart_tx = tx_line;
endmodule

// File: doc/uart_mmio_responder.md
Name: uart_mmio_responder

Overview:
Memory-mapped UART peripheral that acts as a responder on the CPU data port. It accepts the port's address, write data, width, write-enable and zero-extend signals, and returns registered read data one cycle later, matching the writeback stage of the CPU. The memory controller decodes its address window and drives i_sel. The block never stalls the CPU. It contains a TX FIFO, a TX serializer, an RX deserializer and a one-byte RX holding register, with sticky error flags.

Parameters:
TX_DEPTH, 8, TX FIFO entries; must be a power of two and at least 2.
DIV_RESET, 16'd868, reset value of DIVISOR in clocks per bit.

Ports:
i_clk  input  1  system clock
i_rst_n  input  1  asynchronous active-low reset
i_sel  input  1  address-window hit from the memory controller; qualifies every access
i_data_addr  input  32  byte address; only [3:2] (register) and [1:0] (lane) are used
i_data_data  input  32  store data, unshifted (low bits significant)
i_data_width  input  2  0 none, 1 byte, 2 half, 3 word
i_data_we  input  1  1 = store, 0 = load
i_data_zeroextend  input  1  loads: 1 zero-extend, 0 sign-extend
o_data_data  output  32  registered load data
i_uart_rx  input  1  serial input, asynchronous
o_uart_tx  output  1  serial output, idle high

Behaviour:
- Reset: o_data_data=0, o_uart_tx=1, TX FIFO empty, serializer idle, rx_valid=0, all sticky flags 0, DIVISOR=DIV_RESET.
  - Reset is asynchronous; asserting it mid-frame forces o_uart_tx high immediately and discards FIFO contents and any partial RX byte.
- Access condition: access = i_sel && width!=0. Loads have no side effects.
- Read latency: address presented in cycle N; o_data_data is captured at the end of N and held through N+1 until the next access.
- Read timing: reads sample state before any same-edge updates (read-before-write).
- Non-access cycles hold o_data_data.
- Read formatting: word = reg >> (8*addr[1:0]). Truncate to width, then sign- or zero-extend per i_data_zeroextend.
- Writes: honoured only when addr[1:0]==0 and we=1.
  - Byte store writes reg[7:0], half store writes [15:0], word store writes all bits.
  - Misaligned writes are ignored.
- Register map (addr[3:2]):
  - 0 TXDATA: write pushes i_data_data[7:0]. If full before the edge, drop the byte and set tx_overflow. Reads return 0.
  - 1 RXDATA: read {23'b0, rx_valid, rx_byte}. Any write pops (clears rx_valid).
  - 2 STATUS: bit0 tx_full, bit1 tx_empty, bit2 rx_valid, bit3 rx_overrun, bit4 tx_overflow, bit5 rx_frame_err, bit6 tx_busy (FIFO non-empty or serializer active). Writing 1 to bits 3..5 clears them.
  - 3 DIVISOR: 16-bit clocks per bit, read/write. Effective divisor = max(DIVISOR,4). A new value takes effect at the next start bit.
- TX FSM: IDLE -> START -> DATA(8, LSB first) -> STOP -> IDLE.
  - Each state lasts one bit period.
  - A FIFO entry is popped when entering START.
  - If the FIFO is non-empty at the end of STOP, go directly to START with no idle gap.
- Push and pop in the same cycle on a non-full FIFO both succeed; occupancy is unchanged.
- RX path: 2-FF synchronizer, then FSM IDLE -> START -> DATA -> STOP.
  - IDLE->START on a synchronized falling edge.
  - Sample at half period. If the line is high there, abort to IDLE (glitch).
  - Data bits are sampled at one-period intervals thereafter.
  - In STOP, a low sample sets rx_frame_err; the byte is still delivered.
- Byte delivery:
  - If rx_valid=0, or a pop occurs on the same edge: load rx_byte, set rx_valid=1.
  - Otherwise keep the old byte, drop the new one, set rx_overrun.
- Sticky flags: a set and a write-1-clear on the same edge leaves the flag set.

Decomposition:
- Shared package uart_pkg:
  - register offsets;
  - status bit indices;
  - width encodings WIDTH_NONE/BYTE/HALF/WORD (the same encoding as the CPU loadstore[1:0]);
  - TX/RX state enum.
- Sub-module sync_fifo (parameters WIDTH, DEPTH) implements the TX FIFO.
- The RX and TX FSMs stay in this module.

Test Plan:
1. Reset, then load word STATUS -> o_data_data=0x00000002 in the next cycle; load word DIVISOR -> 868.
2. Write DIVISOR=4, then store byte 0xA5 to TXDATA -> o_uart_tx shows 0,1,0,1,0,0,1,0,1,1, each bit held 4 clocks. STATUS bit6 reads 1 during the frame and 0 after.
3. With the serializer stalled by DIVISOR=0xFFFF, push 10 bytes -> STATUS bit0=1, bit4=1. Only the first 9 bytes are transmitted: 1 in the serializer plus 8 in the FIFO. Write 0x10 to STATUS -> bit4 clears.
4. Drive the RX frame 0x81 at divisor 8 -> RXDATA word load returns 0x00000181.
   - Byte load with zeroextend=0 returns 0xFFFFFF81; with zeroextend=1 returns 0x00000081.
   - Half load at addr+1 returns 0x00000001 regardless of zeroextend.
5. Receive 0x11, then 0x22 without a pop -> RXDATA reads 0x111 and STATUS bit3=1.
   - Repeat with a pop write coinciding with the 0x22 stop-bit completion -> reads 0x122 and bit3 stays 0.
6. 1-clock low glitch on RX -> no byte delivered. Frame with stop bit low -> byte delivered and bit5=1. Assert i_rst_n low mid-TX-frame -> o_uart_tx=1 the same cycle.
